// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Each line is its own instance; the controller moves whole lines to and from memory over a req/ack handshake.

module dcache_line #(
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    parameter int WSEL_W = 3
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              fill,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              wr,
    input  logic [WSEL_W-1:0] wsel,
    input  logic [31:0]       wdata,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag,
    output logic [LINE_W-1:0] line
);
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            valid <= 1'b0;
            dirty <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            dirty <= 1'b0;
        end else if (wr) begin
            dirty <= 1'b1;
        end
    end

    // Tag and data are meaningless while valid is low, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag  <= fill_tag;
            line <= fill_line;
        end else if (wr) begin
            line[{wsel, 5'b0} +: 32] <= wdata;
        end
    end
endmodule

module dcache_controller #(
    parameter int INDEX_W = 4,
    parameter int LINE_W  = 256,
    parameter int TAG_W   = 32 - INDEX_W - 5
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int OFF_W     = $clog2(LINE_W / 8);
    localparam int WSEL_W    = OFF_W - 2;

    typedef enum logic [1:0] {IDLE, WB, ALLOC, REFILL} state_t;

    state_t state_q, state_d;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic [WSEL_W-1:0]  wsel;
    logic               req, hit;
    logic               fill, word_wr;
    logic [TAG_W-1:0]   cur_tag;
    logic [LINE_W-1:0]  cur_line;
    logic [31:0]        cur_word;

    logic [NUM_LINES-1:0]             valid_v, dirty_v;
    logic [NUM_LINES-1:0][TAG_W-1:0]  tag_v;
    logic [NUM_LINES-1:0][LINE_W-1:0] line_v;

    logic              en_d, wr_d;
    logic [31:0]       addr_d;
    logic [LINE_W-1:0] wdata_d;

    assign idx     = cpu_addr_i[OFF_W +: INDEX_W];
    assign cpu_tag = cpu_addr_i[31 -: TAG_W];
    assign wsel    = cpu_addr_i[2 +: WSEL_W];

    logic unused_ok;
    assign unused_ok = &{1'b0, cpu_addr_i[1:0]};

    genvar i;
    generate
        for (i = 0; i < NUM_LINES; i++) begin : g_line
            dcache_line #(.TAG_W(TAG_W), .LINE_W(LINE_W), .WSEL_W(WSEL_W)) u_line (
                .clk_i     (clk_i),
                .start_i   (start_i),
                .fill      (fill & (idx == INDEX_W'(i))),
                .fill_tag  (cpu_tag),
                .fill_line (mem_rdata_i),
                .wr        (word_wr & (idx == INDEX_W'(i))),
                .wsel      (wsel),
                .wdata     (cpu_wdata_i),
                .valid     (valid_v[i]),
                .dirty     (dirty_v[i]),
                .tag       (tag_v[i]),
                .line      (line_v[i])
            );
        end
    endgenerate

    assign req      = cpu_read_i | cpu_write_i;
    assign cur_tag  = tag_v[idx];
    assign cur_line = line_v[idx];
    assign hit      = valid_v[idx] & (cur_tag == cpu_tag);
    assign cur_word = cur_line[{wsel, 5'b0} +: 32];

    // With read and write both high the pre-store word is returned; the merge lands at the edge.
    assign cpu_rdata_o = (cpu_read_i & hit) ? cur_word : 32'd0;
    assign cpu_stall_o = (req & ~hit) | (state_q != IDLE);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'd0;
            mem_wdata_o  <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_o <= en_d;
            mem_write_o  <= wr_d;
            mem_addr_o   <= addr_d;
            mem_wdata_o  <= wdata_d;
        end
    end

    // Memory-side outputs are computed one cycle ahead so they leave the block registered.
    always_comb begin
        state_d = state_q;
        en_d    = mem_enable_o;
        wr_d    = mem_write_o;
        addr_d  = mem_addr_o;
        wdata_d = mem_wdata_o;
        fill    = 1'b0;
        word_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (req & ~hit) begin
                    en_d = 1'b1;
                    if (dirty_v[idx]) begin
                        state_d = WB;
                        wr_d    = 1'b1;
                        addr_d  = {cur_tag, idx, {OFF_W{1'b0}}};
                        wdata_d = cur_line;
                    end else begin
                        state_d = ALLOC;
                        wr_d    = 1'b0;
                        addr_d  = {cpu_tag, idx, {OFF_W{1'b0}}};
                    end
                end else if (cpu_write_i & hit) begin
                    word_wr = 1'b1;
                end
            end
            WB: begin
                if (mem_ack_i) begin
                    state_d = ALLOC;
                    wr_d    = 1'b0;
                    addr_d  = {cpu_tag, idx, {OFF_W{1'b0}}};
                end
            end
            ALLOC: begin
                if (mem_ack_i) begin
                    fill    = 1'b1;
                    en_d    = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
